// File: rtl/axi4_switch_pkg.sv
// Shared types and constants for the N-to-1 AXI4-Stream packet switch.
package axi4_switch_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

endpackage

// File: rtl/axi4_stream_skid.sv
// Two-entry skid buffer: registered output stage plus one overflow slot,
// so upstream ready depends only on local state.
module axi4_stream_skid #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [PW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [PW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready
);

  logic          out_valid;
  logic [PW-1:0] out_data;
  logic          skid_valid;
  logic [PW-1:0] skid_data;

  // Valid/ready: a beat moves on any edge where valid and ready are both high;
  // valid never drops and data never changes while the beat waits for ready.
  assign s_ready = !skid_valid;
  assign m_valid = out_valid;
  assign m_data  = out_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || m_ready) begin
      // Output stage is free this edge: refill from the overflow slot first to keep order.
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (s_valid) begin
        out_data  <= s_data;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (s_valid && !skid_valid) begin
      skid_data  <= s_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/axi4_switch_nto1.sv
// N-to-1 AXI4-Stream packet switch: arbitrates whole packets from N slave
// ports onto one master port through a skid buffer.
module axi4_switch_nto1
  import axi4_switch_pkg::*;
#(
  parameter int N_PORTS  = 2,
  parameter int TDATA_L  = 512,
  parameter int TUSER_L  = 81,
  parameter int TKEEP_L  = 16,
  parameter int ARB_MODE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_PORTS-1:0]         s_req_supress,
  input  logic [N_PORTS*TDATA_L-1:0] axi_s_tdata_i,
  input  logic [N_PORTS*TUSER_L-1:0] axi_s_tuser_i,
  input  logic [N_PORTS*TKEEP_L-1:0] axi_s_tkeep_i,
  input  logic [N_PORTS-1:0]         axi_s_tlast_i,
  input  logic [N_PORTS-1:0]         axi_s_tvalid_i,
  output logic [N_PORTS-1:0]         axi_s_tready_o,
  output logic [TDATA_L-1:0]         axi_m0_tdata_o,
  output logic [TUSER_L-1:0]         axi_m0_tuser_o,
  output logic [TKEEP_L-1:0]         axi_m0_tkeep_o,
  output logic                       axi_m0_tlast_o,
  output logic                       axi_m0_tvalid_o,
  input  logic                       axi_m0_tready_i,
  output logic [N_PORTS-1:0]         grant_o,
  output state_e                     dbg_state
);

  localparam int IDX_W = $clog2(N_PORTS);
  localparam int PW    = TDATA_L + TUSER_L + TKEEP_L + 1;

  state_e             state, state_nxt;
  logic [N_PORTS-1:0] grant, grant_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;

  logic [N_PORTS-1:0] cand;
  logic [N_PORTS-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   rr_idx;
  logic               win_found;

  logic [PW-1:0]      sel_payload;
  logic               sel_valid;
  logic               sel_last;
  logic               skid_ready;
  logic               accept;
  logic [PW-1:0]      m_payload;

  assign cand = axi_s_tvalid_i & ~s_req_supress;

  always_comb begin
    win_idx   = '0;
    rr_idx    = '0;
    win_found = 1'b0;
    if (ARB_MODE == ARB_FIXED) begin
      // Descending scan so the lowest-index candidate is written last.
      for (int i = N_PORTS - 1; i >= 0; i--) begin
        if (cand[i]) begin
          win_idx   = IDX_W'(i);
          win_found = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= N_PORTS; k++) begin
        rr_idx = IDX_W'((int'(rr_ptr) + k) % N_PORTS);
        if (!win_found && cand[rr_idx]) begin
          win_idx   = rr_idx;
          win_found = 1'b1;
        end
      end
    end
    win_oh = win_found ? (N_PORTS'(1) << win_idx) : '0;
  end

  always_comb begin
    sel_payload = '0;
    sel_valid   = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant[i]) begin
        sel_payload = sel_payload | {axi_s_tlast_i[i],
                                     axi_s_tkeep_i[i*TKEEP_L +: TKEEP_L],
                                     axi_s_tuser_i[i*TUSER_L +: TUSER_L],
                                     axi_s_tdata_i[i*TDATA_L +: TDATA_L]};
        sel_valid   = sel_valid | axi_s_tvalid_i[i];
      end
    end
  end

  assign sel_last = sel_payload[PW-1];
  assign accept   = (state == ST_PKT) && sel_valid && skid_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      grant  <= '0;
      rr_ptr <= IDX_W'(N_PORTS - 1);
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Suppression is only consulted in IDLE, so an owned packet always completes.
  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    case (state)
      ST_IDLE: begin
        if (win_found) begin
          state_nxt  = ST_PKT;
          grant_nxt  = win_oh;
          rr_ptr_nxt = win_idx;
        end
      end
      ST_PKT: begin
        if (accept && sel_last) begin
          state_nxt = ST_IDLE;
          grant_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  assign axi_s_tready_o = (state == ST_PKT) ? (grant & {N_PORTS{skid_ready}}) : '0;
  assign grant_o        = grant;
  assign dbg_state      = state;

  axi4_stream_skid #(
    .PW(PW)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (sel_payload),
    .s_valid ((state == ST_PKT) && sel_valid),
    .s_ready (skid_ready),
    .m_data  (m_payload),
    .m_valid (axi_m0_tvalid_o),
    .m_ready (axi_m0_tready_i)
  );

  assign {axi_m0_tlast_o, axi_m0_tkeep_o, axi_m0_tuser_o, axi_m0_tdata_o} = m_payload;

endmodule

// File: tb/tb_axi4_switch_nto1.sv
// Directed bench for axi4_switch_nto1: a round-robin 2-port instance carries
// most scenarios, a fixed-priority 4-port instance covers priority arbitration.
module tb_axi4_switch_nto1;
  import axi4_switch_pkg::*;

  localparam int DW = 32;
  localparam int UW = 8;
  localparam int KW = 4;
  localparam int PW = DW + UW + KW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- round-robin instance (N=2) ----------------
  logic [1:0]      rr_supress;
  logic [2*DW-1:0] rr_tdata;
  logic [2*UW-1:0] rr_tuser;
  logic [2*KW-1:0] rr_tkeep;
  logic [1:0]      rr_tlast;
  logic [1:0]      rr_tvalid;
  logic [1:0]      rr_tready;
  logic [DW-1:0]   m0_tdata;
  logic [UW-1:0]   m0_tuser;
  logic [KW-1:0]   m0_tkeep;
  logic            m0_tlast;
  logic            m0_tvalid;
  logic            m0_tready;
  logic [1:0]      rr_grant;
  state_e          rr_state;

  axi4_switch_nto1 #(
    .N_PORTS(2), .TDATA_L(DW), .TUSER_L(UW), .TKEEP_L(KW), .ARB_MODE(ARB_RR)
  ) dut_rr (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_req_supress   (rr_supress),
    .axi_s_tdata_i   (rr_tdata),
    .axi_s_tuser_i   (rr_tuser),
    .axi_s_tkeep_i   (rr_tkeep),
    .axi_s_tlast_i   (rr_tlast),
    .axi_s_tvalid_i  (rr_tvalid),
    .axi_s_tready_o  (rr_tready),
    .axi_m0_tdata_o  (m0_tdata),
    .axi_m0_tuser_o  (m0_tuser),
    .axi_m0_tkeep_o  (m0_tkeep),
    .axi_m0_tlast_o  (m0_tlast),
    .axi_m0_tvalid_o (m0_tvalid),
    .axi_m0_tready_i (m0_tready),
    .grant_o         (rr_grant),
    .dbg_state       (rr_state)
  );

  // ---------------- fixed-priority instance (N=4) ----------------
  logic [3:0]      fp_supress;
  logic [4*DW-1:0] fp_tdata;
  logic [4*UW-1:0] fp_tuser;
  logic [4*KW-1:0] fp_tkeep;
  logic [3:0]      fp_tlast;
  logic [3:0]      fp_tvalid;
  logic [3:0]      fp_tready;
  logic [DW-1:0]   fp_m0_tdata;
  logic [UW-1:0]   fp_m0_tuser;
  logic [KW-1:0]   fp_m0_tkeep;
  logic            fp_m0_tlast;
  logic            fp_m0_tvalid;
  logic            fp_m0_tready;
  logic [3:0]      fp_grant;
  state_e          fp_state;

  axi4_switch_nto1 #(
    .N_PORTS(4), .TDATA_L(DW), .TUSER_L(UW), .TKEEP_L(KW), .ARB_MODE(ARB_FIXED)
  ) dut_fp (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_req_supress   (fp_supress),
    .axi_s_tdata_i   (fp_tdata),
    .axi_s_tuser_i   (fp_tuser),
    .axi_s_tkeep_i   (fp_tkeep),
    .axi_s_tlast_i   (fp_tlast),
    .axi_s_tvalid_i  (fp_tvalid),
    .axi_s_tready_o  (fp_tready),
    .axi_m0_tdata_o  (fp_m0_tdata),
    .axi_m0_tuser_o  (fp_m0_tuser),
    .axi_m0_tkeep_o  (fp_m0_tkeep),
    .axi_m0_tlast_o  (fp_m0_tlast),
    .axi_m0_tvalid_o (fp_m0_tvalid),
    .axi_m0_tready_i (fp_m0_tready),
    .grant_o         (fp_grant),
    .dbg_state       (fp_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] src0_q[$];
  logic [PW-1:0] src1_q[$];
  int            out_cyc[$];
  logic          prev_stall = 1'b0;
  logic [PW-1:0] prev_payload = '0;
  logic          fire0 = 1'b0;
  logic          fire1 = 1'b0;
  logic          toggle_rdy = 1'b0;
  int            n_arb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] beat(input logic [31:0] d, input logic last);
    return {last, d[3:0], d[15:8], d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive();
    rr_tvalid = '0;
    rr_tlast  = '0;
    rr_tdata  = '0;
    rr_tuser  = '0;
    rr_tkeep  = '0;
    if (src0_q.size() > 0) begin
      rr_tvalid[0] = 1'b1;
      {rr_tlast[0], rr_tkeep[3:0], rr_tuser[7:0], rr_tdata[31:0]} = src0_q[0];
    end
    if (src1_q.size() > 0) begin
      rr_tvalid[1] = 1'b1;
      {rr_tlast[1], rr_tkeep[7:4], rr_tuser[15:8], rr_tdata[63:32]} = src1_q[0];
    end
  endtask

  // One clock: observe at negedge, then advance sources just after posedge.
  task automatic tick();
    logic [PW-1:0] pl;
    logic [PW-1:0] e;
    @(negedge clk);
    pl = {m0_tlast, m0_tkeep, m0_tuser, m0_tdata};
    if (prev_stall) begin
      chk("stall_valid_hold", 64'(m0_tvalid), 64'(1));
      chk("stall_data_hold", 64'(pl), 64'(prev_payload));
    end
    prev_stall   = m0_tvalid && !m0_tready;
    prev_payload = pl;
    if (m0_tvalid && m0_tready) begin
      out_cyc.push_back(cyc);
      chk("beat_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_beat", 64'(pl), 64'(e));
      end
    end
    fire0 = rr_tvalid[0] && rr_tready[0];
    fire1 = rr_tvalid[1] && rr_tready[1];
    @(posedge clk);
    #1;
    cyc++;
    if (fire0) void'(src0_q.pop_front());
    if (fire1) void'(src1_q.pop_front());
    if (toggle_rdy) m0_tready = ~m0_tready;
    drive();
  endtask

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rr_supress = '0;
    m0_tready  = 1'b1;
    drive();
    fp_supress   = '0;
    fp_tdata     = {32'hF3F30003, 32'hF2F20002, 32'hF1F10001, 32'hF0F00000};
    fp_tuser     = '0;
    fp_tkeep     = '0;
    fp_tlast     = '0;
    fp_tvalid    = '0;
    fp_m0_tready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m0_tvalid", 64'(m0_tvalid), 64'(0));
    chk("rst_grant", 64'(rr_grant), 64'(0));
    chk("rst_tready", 64'(rr_tready), 64'(0));
    chk("rst_m0_tdata", 64'(m0_tdata), 64'(0));
    chk("rst_state", 64'(rr_state), 64'(ST_IDLE));
    chk("rst_fp_grant", 64'(fp_grant), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Both ports with 2-beat packets: port 0 first after reset, one bubble between packets
    src0_q.push_back(beat(32'h11110001, 1'b0));
    src0_q.push_back(beat(32'h11110002, 1'b1));
    src1_q.push_back(beat(32'h22220001, 1'b0));
    src1_q.push_back(beat(32'h22220002, 1'b1));
    exp_q.push_back(beat(32'h11110001, 1'b0));
    exp_q.push_back(beat(32'h11110002, 1'b1));
    exp_q.push_back(beat(32'h22220001, 1'b0));
    exp_q.push_back(beat(32'h22220002, 1'b1));
    out_cyc.delete();
    drive();
    tick();
    chk("rr_first_grant", 64'(rr_grant), 64'(2'b01));
    drain(20, "rr_drain");
    chk("rr_beat_count", 64'(out_cyc.size()), 64'(4));
    if (out_cyc.size() == 4) begin
      chk("rr_gap_in_pkt0", 64'(out_cyc[1] - out_cyc[0]), 64'(1));
      chk("rr_gap_between", 64'(out_cyc[2] - out_cyc[1]), 64'(2));
      chk("rr_gap_in_pkt1", 64'(out_cyc[3] - out_cyc[2]), 64'(1));
    end

    // Single-beat packet from port 0
    src0_q.push_back(beat(32'hA0010001, 1'b1));
    exp_q.push_back(beat(32'hA0010001, 1'b1));
    drive();
    tick();
    chk("p0_grant", 64'(rr_grant), 64'(2'b01));
    chk("p0_tready", 64'(rr_tready), 64'(2'b01));
    chk("p0_state", 64'(rr_state), 64'(ST_PKT));
    tick();
    chk("p0_grant_clear", 64'(rr_grant), 64'(2'b00));
    chk("p0_tready_clear", 64'(rr_tready), 64'(2'b00));
    chk("p0_m0_tvalid", 64'(m0_tvalid), 64'(1));
    chk("p0_m0_tdata", 64'(m0_tdata), 64'(32'hA0010001));
    chk("p0_m0_tlast", 64'(m0_tlast), 64'(1));
    drain(5, "p0_drain");

    // Suppress port 0 mid-packet: packet completes, port 1 wins next
    src0_q.push_back(beat(32'hC0A00001, 1'b0));
    src0_q.push_back(beat(32'hC0A00002, 1'b0));
    src0_q.push_back(beat(32'hC0A00003, 1'b1));
    src0_q.push_back(beat(32'hC0B00001, 1'b1));
    exp_q.push_back(beat(32'hC0A00001, 1'b0));
    exp_q.push_back(beat(32'hC0A00002, 1'b0));
    exp_q.push_back(beat(32'hC0A00003, 1'b1));
    exp_q.push_back(beat(32'hC0C00001, 1'b1));
    drive();
    tick();
    chk("sup_grant_p0", 64'(rr_grant), 64'(2'b01));
    rr_supress = 2'b01;
    src1_q.push_back(beat(32'hC0C00001, 1'b1));
    drive();
    drain(20, "sup_drain");
    repeat (3) tick();
    chk("sup_p0_blocked_grant", 64'(rr_grant), 64'(2'b00));
    chk("sup_p0_pending", 64'(src0_q.size()), 64'(1));
    rr_supress = 2'b00;
    exp_q.push_back(beat(32'hC0B00001, 1'b1));
    drain(10, "sup_release_drain");

    // m0_tready toggling during a 4-beat packet
    for (int i = 1; i <= 4; i++) begin
      src0_q.push_back(beat(32'hB0A00000 + 32'(i), i == 4));
      exp_q.push_back(beat(32'hB0A00000 + 32'(i), i == 4));
    end
    m0_tready  = 1'b1;
    toggle_rdy = 1'b1;
    drive();
    drain(40, "toggle_drain");
    toggle_rdy = 1'b0;
    m0_tready  = 1'b1;
    tick();

    // Reset pulse after beat 2 of a 4-beat packet
    for (int i = 1; i <= 4; i++) src0_q.push_back(beat(32'hD0D00000 + 32'(i), i == 4));
    exp_q.push_back(beat(32'hD0D00001, 1'b0));
    exp_q.push_back(beat(32'hD0D00002, 1'b0));
    drive();
    drain(20, "rst_pre_drain");
    chk("rst_pre_valid", 64'(m0_tvalid), 64'(1));
    rst_n = 1'b0;
    src0_q.delete();
    drive();
    prev_stall = 1'b0;
    #1;
    chk("rst_mid_tvalid", 64'(m0_tvalid), 64'(0));
    chk("rst_mid_grant", 64'(rr_grant), 64'(0));
    chk("rst_mid_tready", 64'(rr_tready), 64'(0));
    chk("rst_mid_tdata", 64'(m0_tdata), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    src1_q.push_back(beat(32'hE0E00001, 1'b0));
    src1_q.push_back(beat(32'hE0E00002, 1'b1));
    exp_q.push_back(beat(32'hE0E00001, 1'b0));
    exp_q.push_back(beat(32'hE0E00002, 1'b1));
    drive();
    tick();
    chk("post_rst_grant", 64'(rr_grant), 64'(2'b10));
    chk("post_rst_no_out", 64'(m0_tvalid), 64'(0));
    drain(20, "post_rst_drain");

    // Fixed priority: ports 1..3 always valid, port 1 wins every arbitration
    fp_tlast  = 4'b1111;
    fp_tvalid = 4'b1110;
    n_arb = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (fp_grant != 4'b0000) begin
        n_arb++;
        chk("fp_grant", 64'(fp_grant), 64'(4'b0010));
        chk("fp_tready", 64'(fp_tready), 64'(4'b0010));
      end
    end
    chk("fp_arb_count", 64'(n_arb), 64'(8));
    @(posedge clk);
    #1;
    fp_tvalid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
